// File: rtl/instr_enc.sv
// MSP430 instruction encoder: serializes decoded fields into the opcode word plus 0-2 extension words.
// Optional constant-generator re-encoding of immediates is enabled by defining INSTR_ENC_CG_EN.
module instr_enc (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [3:0]  opcode,
    input  logic [9:0]  offset,
    input  logic        BW,
    input  logic        Ad,
    input  logic [1:0]  As,
    input  logic [3:0]  reg_S,
    input  logic [3:0]  reg_D,
    input  logic [15:0] src_ext,
    input  logic [15:0] dst_ext,
    output logic [15:0] MDB_in,
    output logic        mdb_valid,
    input  logic        mdb_ready,
    output logic        last,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, OPW, SRCW, DSTW} state_t;

    state_t      state, state_next;
    logic [15:0] op_word_q, src_q, dst_q;
    logic        need_src_q, need_dst_q;

    logic [15:0] op_word_d;
    logic [3:0]  src_reg;
    logic [1:0]  src_as;
    logic        is_reti, invalid, need_src_d, need_dst_d;
    logic        accept, handshake;

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid & in_ready;
    assign handshake = mdb_valid & mdb_ready;

    // Field decode; the source operand register is reg_S for Format I and reg_D for Format II
    always_comb begin
        src_reg = (fmt == 2'd1) ? reg_S : reg_D;
        src_as  = As;
`ifdef INSTR_ENC_CG_EN
        if (fmt != 2'd3 && As == 2'b11 && src_reg == 4'd0) begin
            case (src_ext)
                16'h0000: begin src_reg = 4'd3; src_as = 2'b00; end
                16'h0001: begin src_reg = 4'd3; src_as = 2'b01; end
                16'h0002: begin src_reg = 4'd3; src_as = 2'b10; end
                16'hFFFF: begin src_reg = 4'd3; src_as = 2'b11; end
                16'h0004: begin src_reg = 4'd2; src_as = 2'b10; end
                16'h0008: begin src_reg = 4'd2; src_as = 2'b11; end
                default:  ;
            endcase
        end
`endif
        is_reti    = (fmt == 2'd2) && (opcode[2:0] == 3'd6);
        invalid    = (fmt == 2'd0) || (fmt == 2'd1 && opcode < 4'd4) ||
                     (fmt == 2'd2 && opcode[2:0] == 3'd7);
        need_src_d = (fmt == 2'd1 || (fmt == 2'd2 && !is_reti)) &&
                     (src_reg != 4'd3) && !(src_reg == 4'd2 && src_as[1]) &&
                     (src_as == 2'b01 || (src_as == 2'b11 && src_reg == 4'd0));
        need_dst_d = (fmt == 2'd1) && Ad;
        case (fmt)
            2'd1:    op_word_d = {opcode, src_reg, Ad, BW, src_as, reg_D};
            2'd2:    op_word_d = is_reti ? {6'b000100, 3'b110, 7'b0000000}
                                         : {6'b000100, opcode[2:0], BW, src_as, src_reg};
            2'd3:    op_word_d = {3'b001, opcode[2:0], offset};
            default: op_word_d = 16'h0000;
        endcase
    end

    // State register and latched instruction; invalid requests only raise err
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_word_q  <= 16'h0000;
            src_q      <= 16'h0000;
            dst_q      <= 16'h0000;
            need_src_q <= 1'b0;
            need_dst_q <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_next;
            err   <= accept & invalid;
            if (accept && !invalid) begin
                op_word_q  <= op_word_d;
                src_q      <= src_ext;
                dst_q      <= dst_ext;
                need_src_q <= need_src_d;
                need_dst_q <= need_dst_d;
            end
        end
    end

    always_comb begin
        state_next = state;
        mdb_valid  = 1'b0;
        MDB_in     = 16'h0000;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !invalid)
                    state_next = OPW;
            end
            OPW: begin
                mdb_valid = 1'b1;
                MDB_in    = op_word_q;
                last      = !need_src_q && !need_dst_q;
                if (handshake)
                    state_next = need_src_q ? SRCW : (need_dst_q ? DSTW : IDLE);
            end
            SRCW: begin
                mdb_valid = 1'b1;
                MDB_in    = src_q;
                last      = !need_dst_q;
                if (handshake)
                    state_next = need_dst_q ? DSTW : IDLE;
            end
            DSTW: begin
                mdb_valid = 1'b1;
                MDB_in    = dst_q;
                last      = 1'b1;
                if (handshake)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_enc.sv
// Scoreboard bench for instr_enc: directed instructions push expected words, a monitor pops them on handshakes.
module tb_instr_enc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [3:0]  opcode;
    logic [9:0]  offset;
    logic        BW, Ad;
    logic [1:0]  As;
    logic [3:0]  reg_S, reg_D;
    logic [15:0] src_ext, dst_ext;
    logic [15:0] MDB_in;
    logic        mdb_valid, mdb_ready, last, err;

    typedef struct packed {
        logic [15:0] word;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    instr_enc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .offset(offset), .BW(BW), .Ad(Ad), .As(As),
        .reg_S(reg_S), .reg_D(reg_D), .src_ext(src_ext), .dst_ext(dst_ext),
        .MDB_in(MDB_in), .mdb_valid(mdb_valid), .mdb_ready(mdb_ready),
        .last(last), .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [15:0] w, input logic l);
        exp_t e;
        e.word = w;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [1:0] f, input logic [3:0] op, input logic [9:0] off,
                                 input logic bw, input logic ad, input logic [1:0] as_,
                                 input logic [3:0] s, input logic [3:0] d,
                                 input logic [15:0] se, input logic [15:0] de);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 16'(in_ready), 16'h0001);
        fmt = f; opcode = op; offset = off; BW = bw; Ad = ad; As = as_;
        reg_S = s; reg_D = d; src_ext = se; dst_ext = de;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0 || !in_ready)
            checkOutput("drain_timeout", 16'(exp_q.size()), 16'h0000);
    endtask

    // Monitor: each word is compared on the cycle the consumer takes it
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (err && mdb_valid)
                    checkOutput("err_with_valid", 16'h0001, 16'h0000);
                if (mdb_valid && mdb_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_word", MDB_in, 16'hXXXX);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        checkOutput("mdb_word", MDB_in, e.word);
                        checkOutput("mdb_last", 16'(last), 16'(e.last));
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; mdb_ready = 1'b1;
        fmt = 2'd0; opcode = 4'd0; offset = 10'd0; BW = 1'b0; Ad = 1'b0; As = 2'b00;
        reg_S = 4'd0; reg_D = 4'd0; src_ext = 16'h0000; dst_ext = 16'h0000;
        #23;
        checkOutput("rst_in_ready", 16'(in_ready), 16'h0001);
        checkOutput("rst_valid", 16'(mdb_valid), 16'h0000);
        checkOutput("rst_MDB_in", MDB_in, 16'h0000);
        checkOutput("rst_last", 16'(last), 16'h0000);
        checkOutput("rst_err", 16'(err), 16'h0000);
        rst = 1'b0;
        @(posedge clk); #1;

        // MOV R4,R5: single word, in_ready back two cycles after acceptance
        pushExp(16'h4405, 1'b1);
        applyStimulus(2'd1, 4'd4, 10'd0, 1'b0, 1'b0, 2'b00, 4'd4, 4'd5, 16'h0, 16'h0);
        checkOutput("mov_busy", 16'(in_ready), 16'h0000);
        @(posedge clk); #1;
        checkOutput("mov_ready_again", 16'(in_ready), 16'h0001);
        waitDrain();

        // ADD 2(R4),6(R5): three words
        pushExp(16'h5495, 1'b0); pushExp(16'h0002, 1'b0); pushExp(16'h0006, 1'b1);
        applyStimulus(2'd1, 4'd5, 10'd0, 1'b0, 1'b1, 2'b01, 4'd4, 4'd5, 16'h0002, 16'h0006);
        waitDrain();

        // JMP cond 7, offset 0x3FE
        pushExp(16'h3FFE, 1'b1);
        applyStimulus(2'd3, 4'd7, 10'h3FE, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
        waitDrain();

        // MOV #8,R5: constant generator or literal immediate
`ifdef INSTR_ENC_CG_EN
        pushExp(16'h4235, 1'b1);
`else
        pushExp(16'h4035, 1'b0); pushExp(16'h0008, 1'b1);
`endif
        applyStimulus(2'd1, 4'd4, 10'd0, 1'b0, 1'b0, 2'b11, 4'd0, 4'd5, 16'h0008, 16'h0);
        waitDrain();

        // R3 source and R2 indirect never need extensions; R2 indexed (absolute) does
        pushExp(16'h4315, 1'b1);
        applyStimulus(2'd1, 4'd4, 10'd0, 1'b0, 1'b0, 2'b01, 4'd3, 4'd5, 16'h1234, 16'h0);
        pushExp(16'h4226, 1'b1);
        applyStimulus(2'd1, 4'd4, 10'd0, 1'b0, 1'b0, 2'b10, 4'd2, 4'd6, 16'h1234, 16'h0);
        pushExp(16'h4216, 1'b0); pushExp(16'h0200, 1'b1);
        applyStimulus(2'd1, 4'd4, 10'd0, 1'b0, 1'b0, 2'b01, 4'd2, 4'd6, 16'h0200, 16'h0);
        waitDrain();

        // Format II: RRC R5, SXT 4(R4), RETI with bits [6:0] forced low
        pushExp(16'h1005, 1'b1);
        applyStimulus(2'd2, 4'd0, 10'd0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd5, 16'h0, 16'h0);
        pushExp(16'h1194, 1'b0); pushExp(16'h0004, 1'b1);
        applyStimulus(2'd2, 4'd3, 10'd0, 1'b0, 1'b0, 2'b01, 4'd0, 4'd4, 16'h0004, 16'h0);
        pushExp(16'h1300, 1'b1);
        applyStimulus(2'd2, 4'd6, 10'd0, 1'b1, 1'b0, 2'b01, 4'd0, 4'd9, 16'h5555, 16'h0);
        waitDrain();

        // Backpressure on the ADD source word
        pushExp(16'h5495, 1'b0); pushExp(16'h0002, 1'b0); pushExp(16'h0006, 1'b1);
        applyStimulus(2'd1, 4'd5, 10'd0, 1'b0, 1'b1, 2'b01, 4'd4, 4'd5, 16'h0002, 16'h0006);
        @(posedge clk); #1;
        mdb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("stall_word", MDB_in, 16'h0002);
            checkOutput("stall_valid", 16'(mdb_valid), 16'h0001);
            checkOutput("stall_last", 16'(last), 16'h0000);
        end
        mdb_ready = 1'b1;
        waitDrain();

        // Invalid instructions: err pulse, nothing emitted
        applyStimulus(2'd0, 4'd4, 10'd0, 1'b0, 1'b0, 2'b00, 4'd4, 4'd5, 16'h0, 16'h0);
        checkOutput("err_fmt0", 16'(err), 16'h0001);
        checkOutput("err_fmt0_valid", 16'(mdb_valid), 16'h0000);
        checkOutput("err_fmt0_ready", 16'(in_ready), 16'h0001);
        @(posedge clk); #1;
        checkOutput("err_clears", 16'(err), 16'h0000);
        applyStimulus(2'd1, 4'd2, 10'd0, 1'b0, 1'b0, 2'b00, 4'd4, 4'd5, 16'h0, 16'h0);
        checkOutput("err_op2", 16'(err), 16'h0001);
        @(posedge clk); #1;
        applyStimulus(2'd2, 4'd7, 10'd0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd5, 16'h0, 16'h0);
        checkOutput("err_opc7", 16'(err), 16'h0001);
        @(posedge clk); #1;
        checkOutput("err_no_valid", 16'(mdb_valid), 16'h0000);

        // Reset during SRCW discards the rest of the instruction
        pushExp(16'h5495, 1'b0); pushExp(16'h0002, 1'b0); pushExp(16'h0006, 1'b1);
        applyStimulus(2'd1, 4'd5, 10'd0, 1'b0, 1'b1, 2'b01, 4'd4, 4'd5, 16'h0002, 16'h0006);
        @(posedge clk); #1;
        checkOutput("pre_rst_word", MDB_in, 16'h0002);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_valid", 16'(mdb_valid), 16'h0000);
        checkOutput("rst_mid_ready", 16'(in_ready), 16'h0001);
        checkOutput("rst_mid_word", MDB_in, 16'h0000);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        pushExp(16'h4405, 1'b1);
        applyStimulus(2'd1, 4'd4, 10'd0, 1'b0, 1'b0, 2'b00, 4'd4, 4'd5, 16'h0, 16'h0);
        waitDrain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
